// File: rtl/mc_controller_pkg.sv
// Shared types for the multicycle controller: opcodes, enable levels,
// FSM states and PC source selection.
package mc_controller_pkg;

    localparam int OPCODE_W = 6;
    localparam int COUNT_W  = 32;

    typedef enum logic [OPCODE_W-1:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        BEQ   = 6'h04,
        ADDI  = 6'h08,
        LW    = 6'h23,
        SW    = 6'h2B
    } OpCode;

    typedef enum logic {
        DISABLE = 1'b0,
        ENABLE  = 1'b1
    } Signal;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } CtrlState;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } PcSrc;

endpackage

// File: rtl/mc_controller_if.sv
// Shared memory port between the controller (master) and the memory (slave):
// one request at a time, completed by mem_ready.
interface mc_controller_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle control FSM for the RTYPE/ADDI/BEQ/LW/SW/J subset; one memory port
// shared by fetch and data access, plus a retired-instruction counter.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    mc_controller_if.master     mem_bus,
    output logic                ir_write,
    output logic                pc_write,
    output PcSrc                pc_src,
    output logic                alu_src_imm,
    output Signal               rf_write,
    output logic                wb_sel,
    output logic                trap,
    output logic [COUNT_W-1:0]  instr_count,
    output logic [2:0]          state_o
);

    CtrlState            state;
    CtrlState            state_next;
    logic [OPCODE_W-1:0] op_q;
    logic [COUNT_W-1:0]  count_q;
    logic                retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                op_q <= opcode;
            end
            if (retire) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // DECODE steers on the live opcode because op_q only captures it at the end of that cycle.
    always_comb begin
        state_next       = state;
        retire           = 1'b0;
        mem_bus.mem_req  = 1'b0;
        mem_bus.mem_we   = 1'b0;
        mem_bus.addr_sel = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        pc_src           = PC_PLUS4;
        alu_src_imm      = 1'b0;
        rf_write         = DISABLE;
        wb_sel           = 1'b0;
        trap             = 1'b0;
        state_o          = state;
        instr_count      = count_q;

        case (state)
            FETCH: begin
                mem_bus.mem_req = 1'b1;
                if (mem_bus.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    RTYPE, ADDI, BEQ, LW, SW: state_next = EXEC;
                    J: begin
                        pc_write   = 1'b1;
                        pc_src     = PC_JUMP;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    default: state_next = TRAP;
                endcase
            end
            EXEC: begin
                alu_src_imm = (op_q == ADDI) || (op_q == LW) || (op_q == SW);
                case (op_q)
                    RTYPE, ADDI: state_next = WB;
                    LW, SW:      state_next = MEM;
                    BEQ: begin
                        pc_write   = zero;
                        pc_src     = PC_BRANCH;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    default: state_next = TRAP;
                endcase
            end
            MEM: begin
                mem_bus.mem_req  = 1'b1;
                mem_bus.addr_sel = 1'b1;
                mem_bus.mem_we   = (op_q == SW);
                if (mem_bus.mem_ready) begin
                    if (op_q == SW) begin
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            WB: begin
                rf_write   = ENABLE;
                wb_sel     = (op_q == LW);
                retire     = 1'b1;
                state_next = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: state_next = FETCH;
        endcase

        // Reset silences every output in the same cycle, before the register catches up.
        if (reset) begin
            mem_bus.mem_req  = 1'b0;
            mem_bus.mem_we   = 1'b0;
            mem_bus.addr_sel = 1'b0;
            ir_write         = 1'b0;
            pc_write         = 1'b0;
            pc_src           = PC_PLUS4;
            alu_src_imm      = 1'b0;
            rf_write         = DISABLE;
            wb_sel           = 1'b0;
            trap             = 1'b0;
            state_o          = 3'd0;
            instr_count      = '0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by cycle
// with hand-derived control values, plus trap, reset and counter wrap.
module tb_mc_controller;
    import mc_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_imm;
    logic        rf_write;
    logic        wb_sel;
    logic        trap;
    logic [31:0] instr_count;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    mc_controller_if mem_bus();

    mc_controller dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .zero        (zero),
        .mem_bus     (mem_bus.master),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_src_imm (alu_src_imm),
        .rf_write    (rf_write),
        .wb_sel      (wb_sel),
        .trap        (trap),
        .instr_count (instr_count),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic z, input logic rdy);
        opcode            = op;
        zero              = z;
        mem_bus.mem_ready = rdy;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] allOutputs();
        return 32'({mem_bus.mem_req, mem_bus.mem_we, mem_bus.addr_sel, ir_write, pc_write,
                    pc_src, alu_src_imm, rf_write, wb_sel, trap, state_o});
    endfunction

    initial begin
        reset = 1'b1;
        applyStimulus(6'h00, 1'b0, 1'b1);
        advance();
        advance();
        applyStimulus(6'h00, 1'b0, 1'b1);
        checkOutput("reset_outputs", allOutputs(), 32'd0);
        checkOutput("reset_count", instr_count, 32'd0);

        // RTYPE, zero-wait memory: FETCH, DECODE, EXEC, WB
        reset = 1'b0;
        applyStimulus(6'h00, 1'b0, 1'b1);
        checkOutput("rt_fetch_state", 32'(state_o), 32'd0);
        checkOutput("rt_fetch_req", 32'(mem_bus.mem_req), 32'd1);
        checkOutput("rt_fetch_irw", 32'(ir_write), 32'd1);
        checkOutput("rt_fetch_pcw", 32'(pc_write), 32'd1);
        checkOutput("rt_fetch_pcsrc", 32'(pc_src), 32'd0);
        checkOutput("rt_fetch_rfw", 32'(rf_write), 32'd0);
        advance();
        applyStimulus(6'h00, 1'b0, 1'b1);
        checkOutput("rt_dec_state", 32'(state_o), 32'd1);
        checkOutput("rt_dec_req", 32'(mem_bus.mem_req), 32'd0);
        checkOutput("rt_dec_pcw", 32'(pc_write), 32'd0);
        advance();
        checkOutput("rt_exec_state", 32'(state_o), 32'd2);
        checkOutput("rt_exec_imm", 32'(alu_src_imm), 32'd0);
        checkOutput("rt_exec_rfw", 32'(rf_write), 32'd0);
        advance();
        checkOutput("rt_wb_state", 32'(state_o), 32'd4);
        checkOutput("rt_wb_rfw", 32'(rf_write), 32'd1);
        checkOutput("rt_wb_sel", 32'(wb_sel), 32'd0);
        advance();
        applyStimulus(6'h00, 1'b0, 1'b0);
        checkOutput("rt_done_state", 32'(state_o), 32'd0);
        checkOutput("rt_count", instr_count, 32'd1);
        checkOutput("idle_irw", 32'(ir_write), 32'd0);

        // LW: 2 wait cycles in FETCH, 3 in MEM -> 10 cycles total
        for (int i = 0; i < 2; i++) begin
            applyStimulus(6'h23, 1'b0, 1'b0);
            checkOutput("lw_fwait_state", 32'(state_o), 32'd0);
            checkOutput("lw_fwait_req", 32'(mem_bus.mem_req), 32'd1);
            checkOutput("lw_fwait_addr", 32'(mem_bus.addr_sel), 32'd0);
            checkOutput("lw_fwait_irw", 32'(ir_write), 32'd0);
            advance();
        end
        applyStimulus(6'h23, 1'b0, 1'b1);
        checkOutput("lw_fetch_state", 32'(state_o), 32'd0);
        checkOutput("lw_fetch_irw", 32'(ir_write), 32'd1);
        advance();
        applyStimulus(6'h23, 1'b0, 1'b0);
        checkOutput("lw_dec_state", 32'(state_o), 32'd1);
        advance();
        checkOutput("lw_exec_state", 32'(state_o), 32'd2);
        checkOutput("lw_exec_imm", 32'(alu_src_imm), 32'd1);
        advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'h23, 1'b0, 1'b0);
            checkOutput("lw_mwait_state", 32'(state_o), 32'd3);
            checkOutput("lw_mwait_req", 32'(mem_bus.mem_req), 32'd1);
            checkOutput("lw_mwait_addr", 32'(mem_bus.addr_sel), 32'd1);
            checkOutput("lw_mwait_we", 32'(mem_bus.mem_we), 32'd0);
            advance();
        end
        applyStimulus(6'h23, 1'b0, 1'b1);
        checkOutput("lw_mem_state", 32'(state_o), 32'd3);
        checkOutput("lw_mem_req", 32'(mem_bus.mem_req), 32'd1);
        advance();
        applyStimulus(6'h23, 1'b0, 1'b0);
        checkOutput("lw_wb_state", 32'(state_o), 32'd4);
        checkOutput("lw_wb_rfw", 32'(rf_write), 32'd1);
        checkOutput("lw_wb_sel", 32'(wb_sel), 32'd1);
        checkOutput("lw_wb_count", instr_count, 32'd1);
        advance();
        checkOutput("lw_done_state", 32'(state_o), 32'd0);
        checkOutput("lw_count", instr_count, 32'd2);

        // SW: MEM writes and retires straight back to FETCH
        applyStimulus(6'h2B, 1'b0, 1'b1);
        advance();
        checkOutput("sw_dec_state", 32'(state_o), 32'd1);
        advance();
        checkOutput("sw_exec_state", 32'(state_o), 32'd2);
        checkOutput("sw_exec_imm", 32'(alu_src_imm), 32'd1);
        advance();
        checkOutput("sw_mem_state", 32'(state_o), 32'd3);
        checkOutput("sw_mem_we", 32'(mem_bus.mem_we), 32'd1);
        checkOutput("sw_mem_addr", 32'(mem_bus.addr_sel), 32'd1);
        checkOutput("sw_mem_rfw", 32'(rf_write), 32'd0);
        advance();
        applyStimulus(6'h2B, 1'b0, 1'b0);
        checkOutput("sw_no_wb_state", 32'(state_o), 32'd0);
        checkOutput("sw_count", instr_count, 32'd3);

        // BEQ taken
        applyStimulus(6'h04, 1'b1, 1'b1);
        advance();
        checkOutput("beq1_dec_state", 32'(state_o), 32'd1);
        advance();
        checkOutput("beq1_exec_state", 32'(state_o), 32'd2);
        checkOutput("beq1_exec_pcw", 32'(pc_write), 32'd1);
        checkOutput("beq1_exec_pcsrc", 32'(pc_src), 32'd1);
        checkOutput("beq1_exec_imm", 32'(alu_src_imm), 32'd0);
        advance();
        applyStimulus(6'h04, 1'b0, 1'b0);
        checkOutput("beq1_done_state", 32'(state_o), 32'd0);
        checkOutput("beq1_count", instr_count, 32'd4);

        // BEQ not taken; mem_ready high in EXEC must be ignored
        applyStimulus(6'h04, 1'b0, 1'b1);
        advance();
        advance();
        applyStimulus(6'h04, 1'b0, 1'b1);
        checkOutput("beq0_exec_state", 32'(state_o), 32'd2);
        checkOutput("beq0_exec_pcw", 32'(pc_write), 32'd0);
        checkOutput("beq0_exec_req", 32'(mem_bus.mem_req), 32'd0);
        advance();
        applyStimulus(6'h04, 1'b0, 1'b0);
        checkOutput("beq0_done_state", 32'(state_o), 32'd0);
        checkOutput("beq0_count", instr_count, 32'd5);

        // J: jump issued in DECODE, two cycles total
        applyStimulus(6'h02, 1'b0, 1'b1);
        advance();
        checkOutput("j_dec_state", 32'(state_o), 32'd1);
        checkOutput("j_dec_pcw", 32'(pc_write), 32'd1);
        checkOutput("j_dec_pcsrc", 32'(pc_src), 32'd2);
        advance();
        applyStimulus(6'h02, 1'b0, 1'b0);
        checkOutput("j_done_state", 32'(state_o), 32'd0);
        checkOutput("j_count", instr_count, 32'd6);

        // Illegal opcode parks in TRAP until reset
        applyStimulus(6'h3F, 1'b0, 1'b1);
        advance();
        checkOutput("ill_dec_state", 32'(state_o), 32'd1);
        checkOutput("ill_dec_pcw", 32'(pc_write), 32'd0);
        advance();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(6'h00, 1'b0, 1'(i % 2));
            checkOutput("trap_state", 32'(state_o), 32'd5);
            checkOutput("trap_flag", 32'(trap), 32'd1);
            checkOutput("trap_req", 32'(mem_bus.mem_req), 32'd0);
            checkOutput("trap_count", instr_count, 32'd6);
            advance();
        end
        reset = 1'b1;
        applyStimulus(6'h00, 1'b0, 1'b0);
        checkOutput("trap_rst_outputs", allOutputs(), 32'd0);
        advance();
        reset = 1'b0;
        applyStimulus(6'h00, 1'b0, 1'b0);
        checkOutput("trap_rel_state", 32'(state_o), 32'd0);
        checkOutput("trap_rel_flag", 32'(trap), 32'd0);
        checkOutput("trap_rel_req", 32'(mem_bus.mem_req), 32'd1);
        checkOutput("trap_rel_count", instr_count, 32'd0);

        // Reset while LW waits in MEM
        applyStimulus(6'h23, 1'b0, 1'b1);
        advance();
        advance();
        advance();
        applyStimulus(6'h23, 1'b0, 1'b0);
        checkOutput("mrst_mem_state", 32'(state_o), 32'd3);
        reset = 1'b1;
        advance();
        applyStimulus(6'h23, 1'b0, 1'b1);
        checkOutput("mrst_outputs", allOutputs(), 32'd0);
        checkOutput("mrst_count", instr_count, 32'd0);
        reset = 1'b0;
        applyStimulus(6'h23, 1'b0, 1'b0);
        checkOutput("mrst_rel_state", 32'(state_o), 32'd0);
        checkOutput("mrst_rel_req", 32'(mem_bus.mem_req), 32'd1);
        checkOutput("mrst_rel_addr", 32'(mem_bus.addr_sel), 32'd0);
        advance();
        checkOutput("mrst_no_retire", instr_count, 32'd0);

        // Counter wrap via a J retiring from 0xFFFF_FFFF
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        #1;
        checkOutput("wrap_preset", instr_count, 32'hFFFF_FFFF);
        advance();
        applyStimulus(6'h02, 1'b0, 1'b1);
        advance();
        checkOutput("wrap_dec_state", 32'(state_o), 32'd1);
        advance();
        applyStimulus(6'h02, 1'b0, 1'b0);
        checkOutput("wrap_count", instr_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
